// File: rtl/spike_event_fifo.sv
// Serialises each captured spike vector into {timestamp, neuron index} events
// and queues them in a first-word-fall-through FIFO with loss counters.
module spike_event_fifo #(
   parameter int NUM_OUTPUTS = 1,
   parameter int DEPTH       = 64,
   parameter int TS_WIDTH    = 16,
   parameter int IDX_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [NUM_OUTPUTS-1:0]        spike_in,
   input  logic [31:0]                   sim_time_in,
   input  logic                          rd_en,
   output logic [TS_WIDTH+IDX_WIDTH-1:0] rd_data,
   output logic                          rd_valid,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          full,
   output logic [31:0]                   drop_cnt,
   output logic [31:0]                   overrun_cnt,
   output logic                          busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DW    = TS_WIDTH + IDX_WIDTH;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                 state_q;
   logic [NUM_OUTPUTS-1:0] scan_vec_q, scan_vec_d;
   logic [TS_WIDTH-1:0]    scan_ts_q;
   logic [DW-1:0]          mem_q [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]       count_q;
   logic [31:0]            drop_q, overrun_q;
   logic [IDX_WIDTH-1:0]   low_idx;
   logic                   spike_any, push, pop_ok, push_ok;
   logic                   unused_time;

   assign unused_time = ^sim_time_in;

   // Lowest set bit of the scan vector; x & (x-1) clears exactly that bit.
   always_comb begin
      low_idx = '0;
      for (int unsigned i = NUM_OUTPUTS; i > 0; i--) begin
         if (scan_vec_q[i-1]) low_idx = IDX_WIDTH'(i - 1);
      end
      scan_vec_d = scan_vec_q & (scan_vec_q - NUM_OUTPUTS'(1));
   end

   assign spike_any = |spike_in;
   assign push      = (state_q == SCAN);
   assign pop_ok    = rd_en && (count_q != '0);
   assign push_ok   = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         scan_vec_q <= '0;
         scan_ts_q  <= '0;
         overrun_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (en && spike_any) begin
                  scan_vec_q <= spike_in;
                  scan_ts_q  <= sim_time_in[TS_WIDTH-1:0];
                  state_q    <= SCAN;
               end
            end
            SCAN: begin
               scan_vec_q <= scan_vec_d;
               if (scan_vec_d == '0) state_q <= IDLE;
               if (en && spike_any && (overrun_q != '1)) overrun_q <= overrun_q + 32'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
         if (push && !push_ok && (drop_q != '1)) drop_q <= drop_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_ok) mem_q[wr_ptr_q] <= {scan_ts_q, low_idx};
   end

   assign rd_valid    = (count_q != '0);
   assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign count       = count_q;
   assign full        = (count_q == CNT_W'(DEPTH));
   assign drop_cnt    = drop_q;
   assign overrun_cnt = overrun_q;
   assign busy        = (state_q == SCAN);

endmodule

// File: tb/tb_spike_event_fifo.sv
// Directed bench for spike_event_fifo with DEPTH=4 and four spike inputs.
module tb_spike_event_fifo;

   logic        clk = 1'b0;
   logic        rst, en, rd_en;
   logic [3:0]  spike_in;
   logic [31:0] sim_time_in;
   logic [31:0] rd_data;
   logic        rd_valid, full, busy;
   logic [2:0]  count;
   logic [31:0] drop_cnt, overrun_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   spike_event_fifo #(.NUM_OUTPUTS(4), .DEPTH(4), .TS_WIDTH(16), .IDX_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .sim_time_in(sim_time_in),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full),
      .drop_cnt(drop_cnt), .overrun_cnt(overrun_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ev(input int ts, input int idx);
      return {ts[15:0], idx[15:0]};
   endfunction

   task automatic capture(input logic [3:0] v, input logic [31:0] t);
      en = 1'b1; spike_in = v; sim_time_in = t;
      tick();
      en = 1'b0; spike_in = '0;
   endtask

   task automatic pop_expect(input string tag, input logic [31:0] e);
      check({tag, "_valid"}, 64'(rd_valid), 64'd1);
      check({tag, "_data"}, 64'(rd_data), 64'(e));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 64'(rd_valid), 64'd0);
      check({tag, "_count"}, 64'(count), 64'd0);
      check({tag, "_full"}, 64'(full), 64'd0);
      check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
      check({tag, "_ovr"}, 64'(overrun_cnt), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_data"}, 64'(rd_data), 64'd0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; rd_en = 1'b0; spike_in = '0; sim_time_in = '0;
      tick(); tick();
      rst = 1'b0;
      check_all_zero("reset");

      // Single vector 1010 at t=7
      capture(4'b1010, 32'd7);
      check("v1_busy0", 64'(busy), 64'd1);
      check("v1_cnt0", 64'(count), 64'd0);
      tick();
      check("v1_busy1", 64'(busy), 64'd1);
      check("v1_cnt1", 64'(count), 64'd1);
      tick();
      check("v1_busy2", 64'(busy), 64'd0);
      check("v1_cnt2", 64'(count), 64'd2);
      pop_expect("v1_e0", ev(7, 1));
      pop_expect("v1_e1", ev(7, 3));
      check("v1_empty", 64'(rd_valid), 64'd0);

      // Overrun: new vector arrives while scanning
      capture(4'b1111, 32'd0);
      en = 1'b1; spike_in = 4'b0001; sim_time_in = 32'd1;
      tick();
      en = 1'b0; spike_in = '0;
      check("ovr_cnt", 64'(overrun_cnt), 64'd1);
      tick(); tick(); tick();
      check("ovr_busy", 64'(busy), 64'd0);
      check("ovr_count", 64'(count), 64'd4);
      check("ovr_full", 64'(full), 64'd1);
      check("ovr_drop", 64'(drop_cnt), 64'd0);
      for (int k = 0; k < 4; k++) pop_expect($sformatf("ovr_e%0d", k), ev(0, k));
      check("ovr_drained", 64'(count), 64'd0);

      // Six single-spike vectors into a 4-deep FIFO
      for (int i = 0; i < 6; i++) begin
         capture(4'(1 << (i % 4)), 32'(10 + i));
         tick();
      end
      check("drop_count", 64'(count), 64'd4);
      check("drop_full", 64'(full), 64'd1);
      check("drop_cnt", 64'(drop_cnt), 64'd2);
      check("drop_head", 64'(rd_data), 64'(ev(10, 0)));

      // Push and pop in the same cycle while full
      capture(4'b0001, 32'd20);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("pp_count", 64'(count), 64'd4);
      check("pp_drop", 64'(drop_cnt), 64'd2);
      pop_expect("pp_e0", ev(11, 1));
      pop_expect("pp_e1", ev(12, 2));
      pop_expect("pp_e2", ev(13, 3));
      pop_expect("pp_e3", ev(20, 0));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("empty_pop_count", 64'(count), 64'd0);
      check("empty_pop_valid", 64'(rd_valid), 64'd0);

      // Push and pop in the same cycle while empty
      capture(4'b0100, 32'd30);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("pe_count", 64'(count), 64'd1);
      pop_expect("pe_e0", ev(30, 2));

      // Reset in the middle of a scan
      capture(4'b1111, 32'd40);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("midrst");

      // Timestamp truncation after reset
      capture(4'b0010, 32'd65536);
      tick();
      check("wrap_count", 64'(count), 64'd1);
      pop_expect("wrap_e0", ev(0, 1));
      capture(4'b1000, 32'h0001_0005);
      tick();
      pop_expect("wrap_e1", ev(5, 3));
      check("wrap_busy", 64'(busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spike_event_fifo.md
Name: spike_event_fifo

Overview:
- Sits directly downstream of if_network, alongside spike_counter.
- Turns the per-cycle spike_out vector into a stream of {timestamp, neuron index} events.
- Queues the events in a first-word-fall-through FIFO so that axi_cfg_regs can read exact spike timing, not just totals.
- Counts overflow and overrun losses so software can tell whether a captured trace is complete.

Parameters:
- NUM_OUTPUTS, 1, width of the spike vector (output neurons of the last layer).
- DEPTH, 64, number of FIFO entries; must be a power of 2, minimum 2.
- TS_WIDTH, 16, timestamp field width; the low bits of the sim-time count are kept.
- IDX_WIDTH, 16, neuron index field width; must satisfy 2^IDX_WIDTH >= NUM_OUTPUTS.

Ports:
- clk, input, 1, system clock (S_AXI_ACLK).
- rst, input, 1, synchronous active-high reset; driven by network_rst.
- en, input, 1, capture enable; driven by network_en.
- spike_in, input, NUM_OUTPUTS, spike vector from if_network.
- sim_time_in, input, 32, current simulation time count.
- rd_en, input, 1, single-cycle pop strobe from axi_cfg_regs.
- rd_data, output, TS_WIDTH+IDX_WIDTH, head entry; layout is {ts, idx}.
- rd_valid, output, 1, FIFO not empty.
- count, output, clog2(DEPTH)+1, current occupancy.
- full, output, 1, count == DEPTH.
- drop_cnt, output, 32, events lost because the FIFO was full.
- overrun_cnt, output, 32, spike vectors lost because the scanner was busy.
- busy, output, 1, scanner holds unserialised events.

Behaviour:
- Reset:
  - rd_valid=0, count=0, full=0, drop_cnt=0, overrun_cnt=0, busy=0.
  - rd_data=0; the pointers, scan vector and latched timestamp all clear.
  - Reset mid-scan discards pending events and the FIFO contents with no partial push.
- Capture state machine, two states:
  - IDLE: if en=1 and spike_in != 0, latch spike_in into scan_vec and sim_time_in[TS_WIDTH-1:0] into scan_ts, then go to SCAN. en=0 or spike_in=0 leaves the block in IDLE and does nothing.
  - SCAN: each cycle, emit one event for the lowest set bit k of scan_vec, push {scan_ts, k}, and clear bit k. When the cleared vector becomes 0, go to IDLE. Latency is one event per cycle, the first pushed the cycle after capture.
  - A vector of n set bits occupies SCAN for exactly n cycles.
  - The block can capture again in the cycle it returns to IDLE; back-to-back single-spike vectors are therefore accepted every other cycle.
- Overrun:
  - In SCAN, en=1 with spike_in != 0 means the new vector is discarded and overrun_cnt increments by 1.
  - The counter saturates at 2^32-1.
- FIFO:
  - First-word-fall-through: rd_data always shows the head entry while rd_valid=1.
  - rd_en pops on the rising edge; the next entry is visible the cycle after.
  - rd_en while empty is ignored: no pointer or count change.
  - A push while full with no pop drops the event and increments drop_cnt (saturating).
  - Simultaneous push and pop while full: both succeed and count stays DEPTH.
  - Simultaneous push and pop while empty: the push succeeds, the pop is ignored, and count becomes 1.
  - Pointers wrap modulo DEPTH.
- Widths:
  - idx is zero-extended to IDX_WIDTH.
  - ts is truncated to TS_WIDTH bits; it wraps silently with no flag.

Test Plan:
- Reset with DEPTH=4 and NUM_OUTPUTS=4 -> every output is 0 and rd_valid=0.
- Single vector: spike_in=4'b1010 with sim_time_in=7, en=1 for one cycle -> busy=1 for 2 cycles; the FIFO holds {7,1} then {7,3}; count=2; two pops return them in that order and rd_valid drops to 0.
- Overrun: 4'b1111 at t=0, then 4'b0001 at t=1 while in SCAN -> overrun_cnt=1 and 4 events, all with ts=0.
- Full and drop: DEPTH=4 with 6 single-spike vectors and no reads -> count=4, full=1, drop_cnt=2; the first 4 events are retained in order.
- Simultaneous push and pop at full -> count stays 4 and drop_cnt does not change; a pop on an empty FIFO leaves count=0.
- Mid-scan reset: assert rst during SCAN of 4'b1111 -> the next cycle shows all outputs 0; after release, a new vector is captured normally and the timestamp wraps correctly at sim_time_in=65536 -> ts=0.
